// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant table and key-schedule FSM states.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned RIDX_W    = 4;

  // Rcon[1..10]; RCON[1] is the leftmost byte.
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_sub_c
);

  // Entry 0x00 occupies the top byte, so entry a lives at bit offset (255-a)*8.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_off;

  assign w_off   = {~i_a, 3'b000};
  assign o_sub_c = SBOX_TBL[w_off +: 8];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store.
// Optional build macro AES_RK_READ_REVERSE_EN maps RK_ADDR a to round key 10-a.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR    = AES_NR,
  parameter int unsigned KEY_W = AES_KEY_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [0:KEY_W-1] CIPHER_KEY,
  output logic             BUSY,
  output logic             KEYS_VALID,
  input  logic [3:0]       RK_ADDR,
  output logic [0:KEY_W-1] RK_DATA
);

  if (NR != 10 || KEY_W != 128) begin : g_cfg_chk
    $error("aes_key_expand_seq supports only AES-128 (NR=10, KEY_W=128)");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RIDX_W-1:0]   r_rcnt;
  logic [KEY_W-1:0]    r_slot [NR+1];
  logic                r_busy;
  logic                r_valid;
  logic [KEY_W-1:0]    r_rk;

  logic                w_load;
  logic                w_step;
  logic [RIDX_W-1:0]   w_prev_idx;
  logic [KEY_W-1:0]    w_prev;
  logic [31:0]         w_rot;
  logic [31:0]         w_sub;
  logic [31:0]         w_t;
  logic [31:0]         w_w4;
  logic [31:0]         w_w5;
  logic [31:0]         w_w6;
  logic [31:0]         w_w7;
  logic [KEY_W-1:0]    w_next_key;
  logic [RIDX_W-1:0]   w_rd_idx;
  logic                w_rd_ok;

  // Next-state decode; START is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (START) begin
          w_load      = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_step = 1'b1;
        if (r_rcnt == RIDX_W'(NR)) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Round function on the previously stored key.
  assign w_prev_idx = r_rcnt - RIDX_W'(1);
  assign w_prev     = r_slot[w_prev_idx];
  assign w_rot      = {w_prev[23:0], w_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_a     (w_rot[8*g +: 8]),
      .o_sub_c (w_sub[8*g +: 8])
    );
  end

  assign w_t        = w_sub ^ {RCON[r_rcnt], 24'h000000};
  assign w_w4       = w_prev[127:96] ^ w_t;
  assign w_w5       = w_prev[95:64]  ^ w_w4;
  assign w_w6       = w_prev[63:32]  ^ w_w5;
  assign w_w7       = w_prev[31:0]   ^ w_w6;
  assign w_next_key = {w_w4, w_w5, w_w6, w_w7};

`ifdef AES_RK_READ_REVERSE_EN
  assign w_rd_idx = RIDX_W'(NR) - RK_ADDR;
`else
  assign w_rd_idx = RK_ADDR;
`endif
  assign w_rd_ok  = (RK_ADDR <= RIDX_W'(NR));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_rk    <= '0;
      for (int unsigned i = 0; i <= NR; i++) r_slot[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == EXPAND);
      r_valid <= (w_state_nxt == DONE);
      if (w_load) begin
        r_slot[0] <= CIPHER_KEY;
        r_rcnt    <= RIDX_W'(1);
      end else if (w_step) begin
        r_slot[r_rcnt] <= w_next_key;
        r_rcnt         <= r_rcnt + RIDX_W'(1);
      end
      r_rk <= w_rd_ok ? r_slot[w_rd_idx] : '0;
    end
  end

  assign BUSY       = r_busy;
  assign KEYS_VALID = r_valid;
  assign RK_DATA    = r_rk;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors plus random keys against a GF(2^8) model.
module tb_aes_key_expand_seq;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] key;
  logic         busy;
  logic         valid;
  logic [3:0]   rk_addr;
  logic [0:127] rk_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] mk [11];

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start),
    .CIPHER_KEY (key),
    .BUSY       (busy),
    .KEYS_VALID (valid),
    .RK_ADDR    (rk_addr),
    .RK_DATA    (rk_data)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from multiplicative inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 KeyExpansion over w[0..43].
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int slot_of(input int a);
`ifdef AES_RK_READ_REVERSE_EN
    return 10 - a;
`else
    return a;
`endif
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
    @(negedge clk);
    rk_addr = a;
    @(posedge clk);
    #1;
    d = rk_data;
  endtask

  task automatic check_all(input string nm);
    logic [127:0] d;
    for (int a = 0; a < 11; a++) begin
      read_rk(4'(a), d);
      check($sformatf("%s_a%0d", nm, a), d, mk[slot_of(a)]);
    end
  endtask

  // Leaves time at E0+1; CIPHER_KEY is scrambled afterwards.
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key   = ~k;
  endtask

  task automatic wait_done(input string nm, input int cyc0, input int exp_cyc);
    int n;
    n = cyc0;
    while (!valid && n < 40) begin
      check_b($sformatf("%s_busy_c%0d", nm, n), busy, 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_latency", nm), 128'(n), 128'(exp_cyc));
    check_b($sformatf("%s_busy_end", nm), busy, 1'b0);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] rk;

`ifdef AES_RK_READ_REVERSE_EN
    tbl[0] = '{4'd0,  FIPS_RK10};
    tbl[1] = '{4'd10, FIPS_KEY};
    tbl[2] = '{4'd15, 128'h0};
    tbl[3] = '{4'd9,  FIPS_RK1};
    tbl[4] = '{4'd11, 128'h0};
`else
    tbl[0] = '{4'd0,  FIPS_KEY};
    tbl[1] = '{4'd1,  FIPS_RK1};
    tbl[2] = '{4'd10, FIPS_RK10};
    tbl[3] = '{4'd15, 128'h0};
    tbl[4] = '{4'd12, 128'h0};
`endif

    rst_n = 1'b0; start = 1'b0; key = '0; rk_addr = '0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_valid", valid, 1'b0);
    check("rst_rkdata", rk_data, 128'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_b("idle_busy", busy, 1'b0);
    check_b("idle_valid", valid, 1'b0);
    check("idle_rkdata", rk_data, 128'h0);

    // FIPS-197 key against constants, then all slots against the model.
    model_expand(FIPS_KEY);
    pulse_start(FIPS_KEY);
    wait_done("fips", 0, 10);
    for (int i = 0; i < 5; i++) begin
      read_rk(tbl[i].addr, d);
      check($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), d, tbl[i].exp);
    end
    check_all("fips");

    // START during EXPAND with another key must be ignored.
    pulse_start(FIPS_KEY);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    wait_done("ign", 4, 10);
    check_all("ign");

    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      pulse_start(rk);
      wait_done($sformatf("rnd%0d", r), 0, 10);
      check_all($sformatf("rnd%0d", r));
    end

    // Restart from DONE with the all-zero key.
    model_expand(128'h0);
    pulse_start(128'h0);
    wait_done("zero", 0, 10);
    read_rk(4'(slot_of(1)), d);
    check("zero_rk1", d, ZERO_RK1);
    read_rk(4'(slot_of(10)), d);
    check("zero_rk10", d, ZERO_RK10);
    check_all("zero");

    // Reset mid-expansion.
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_b("arst_busy", busy, 1'b0);
    check_b("arst_valid", valid, 1'b0);
    check("arst_rkdata", rk_data, 128'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int r = 0; r < 11; r++) mk[r] = '0;
    check_all("arst");
    check_b("arst_busy_after", busy, 1'b0);
    check_b("arst_valid_after", valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Iterative AES-128 key schedule that sits directly upstream of AES_Decryption.
- Expands CIPHER_KEY into round keys 0..10, one round key per clock, and stores all 11 keys in an internal register file.
- Exposes the stored keys through a registered read port, so the decryption datapath can fetch them in inverse order (10 down to 0).

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; elaboration error otherwise.
- KEY_W, 128, key and round-key width in bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle pulse; latch CIPHER_KEY and begin expansion.
- CIPHER_KEY  input  [0:127]  cipher key; bits [0:7] = byte 0 (big-endian, MSB-first).
- BUSY  output  1  high while expansion is in progress.
- KEYS_VALID  output  1  high when all 11 round keys are stored and stable.
- RK_ADDR  input  4  round-key index to read, 0..10.
- RK_DATA  output  [0:127]  round key at RK_ADDR, registered.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, BUSY=0, KEYS_VALID=0, RK_DATA=0, round counter=0, all 11 key slots cleared to 0.
- States:
  - IDLE: START=1 -> slot0<=CIPHER_KEY, rcnt<=1, go to EXPAND.
  - EXPAND: each edge writes slot[rcnt]=f(slot[rcnt-1], Rcon[rcnt]) and increments rcnt. The edge that writes slot 10 goes to DONE.
  - DONE: KEYS_VALID=1. START=1 -> slot0<=CIPHER_KEY, KEYS_VALID<=0, rcnt<=1, go to EXPAND (same edge).
- Latency: START sampled at edge E0; slots 1..10 written at E1..E10; KEYS_VALID=1 and BUSY=0 from E10.
- BUSY is 1 from E0 through E9; BUSY and KEYS_VALID are never both 1.
- Round function, per FIPS-197, with w0..w3 the previous key's words:
  - t = SubWord(RotWord(w3)) xor {Rcon,00,00,00}
  - w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6
  - RotWord: byte rotate left by one byte.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- START while in EXPAND is ignored: no restart, and CIPHER_KEY is not re-sampled.
- CIPHER_KEY is sampled only on the START edge; later changes have no effect.
- Read port:
  - RK_DATA <= slot[map(RK_ADDR)] on every edge, so there is 1-cycle read latency in all states.
  - RK_ADDR > 10 -> RK_DATA <= 0.
  - Reads during EXPAND return whatever the slot currently holds; the consumer must wait for KEYS_VALID.
- Reset asserted mid-expansion aborts the expansion immediately and returns the block to the reset state.

Optional Feature:
- Macro: AES_RK_READ_REVERSE_EN.
- Defined: map(a) = 10 - a for a <= 10. RK_ADDR=0 returns round key 10, matching the decryption round order. Addresses > 10 still return 0.
- Undefined: map(a) = a (natural order).
- The macro affects only the read mapping; expansion is identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - NR and KEY_W constants;
  - the Rcon table as a 10-entry byte constant array;
  - the state enum (IDLE, EXPAND, DONE).
- One natural sub-module: aes_sbox, a combinational 8-bit forward S-box. Instantiate it 4 times for SubWord.
- aes_sbox is also reusable by the encryption path.

Test Plan:
- Reset: hold RST_N=0 -> BUSY=0, KEYS_VALID=0, RK_DATA=0. Release with no START -> outputs unchanged.
- FIPS-197 key 2B7E151628AED2A6ABF7158809CF4F3C, START pulse:
  - BUSY high 10 cycles; KEYS_VALID rises 10 cycles after the START edge.
  - Forward build: RK_ADDR=1 -> A0FAFE1788542CB123A339392A6C7605; RK_ADDR=10 -> D014F9A8C9EE2589E13F0CC8B6630CA6; RK_ADDR=0 -> the cipher key.
- AES_RK_READ_REVERSE_EN build, same key: RK_ADDR=0 -> D014F9A8C9EE2589E13F0CC8B6630CA6; RK_ADDR=10 -> 2B7E151628AED2A6ABF7158809CF4F3C; RK_ADDR=15 -> 0.
- START re-pulsed at cycle 4 of EXPAND with a different CIPHER_KEY -> ignored; completion timing and keys match the first key.
- START in DONE with all-zero key:
  - KEYS_VALID drops at that edge and returns 10 cycles later.
  - Round key 1 = 62636363626363636263636362636363.
  - Round key 10 = B4EF5BCB3E92E21123E951CF6F8F188E.
- RST_N pulsed low at cycle 5 of EXPAND -> BUSY and KEYS_VALID drop asynchronously; all slots read 0 after release.
